// File: rtl/mem_arbiter.sv
// Two-master round-robin arbiter sharing one SRAM slave; grant held until s_ack.
// Optional grant watchdog enabled by defining ARB_TIMEOUT_EN.
module mem_arbiter #(
   parameter int unsigned AW             = 32,
   parameter int unsigned DW             = 32,
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              m0_sel,
   input  logic              m0_wen,
   input  logic [AW-1:0]     m0_addr,
   input  logic [DW-1:0]     m0_wdata,
   input  logic [DW/8-1:0]   m0_wmask,
   output logic [DW-1:0]     m0_rdata,
   output logic              m0_ack,
   output logic              m0_err,
   input  logic              m1_sel,
   input  logic              m1_wen,
   input  logic [AW-1:0]     m1_addr,
   input  logic [DW-1:0]     m1_wdata,
   input  logic [DW/8-1:0]   m1_wmask,
   output logic [DW-1:0]     m1_rdata,
   output logic              m1_ack,
   output logic              m1_err,
   output logic              s_sel,
   output logic              s_we,
   output logic [DW/8-1:0]   s_byte_en,
   output logic [AW-1:0]     s_addr,
   output logic [DW-1:0]     s_din,
   input  logic [DW-1:0]     s_dout,
   input  logic              s_ack
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      GNT0 = 2'd1,
      GNT1 = 2'd2
   } state_t;

   state_t state_q, state_d;
   logic   last_gnt_q, last_gnt_d;
   logic   timeout_hit;

   if (TIMEOUT_CYCLES == 0) begin : g_cfg_check
      $error("mem_arbiter: TIMEOUT_CYCLES must be non-zero");
   end

`ifdef ARB_TIMEOUT_EN
   localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);

   logic [CW-1:0] cnt_q;

   // Counts grant cycles without s_ack; cleared whenever the arbiter is idle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else if (state_q == IDLE) begin
         cnt_q <= '0;
      end else if (!s_ack) begin
         cnt_q <= cnt_q + CW'(1);
      end
   end

   assign timeout_hit = (state_q != IDLE) && !s_ack &&
                        (cnt_q == CW'(TIMEOUT_CYCLES - 1));
`else
   assign timeout_hit = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         last_gnt_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         last_gnt_q <= last_gnt_d;
      end
   end

   // Arbitration, slave mux and completion path.
   always_comb begin
      state_d    = state_q;
      last_gnt_d = last_gnt_q;
      s_sel      = 1'b0;
      s_we       = 1'b0;
      s_byte_en  = '0;
      s_addr     = '0;
      s_din      = '0;
      m0_rdata   = '0;
      m0_ack     = 1'b0;
      m0_err     = 1'b0;
      m1_rdata   = '0;
      m1_ack     = 1'b0;
      m1_err     = 1'b0;

      case (state_q)
         IDLE: begin
            if (m0_sel && m1_sel) begin
               state_d = last_gnt_q ? GNT0 : GNT1;
            end else if (m0_sel) begin
               state_d = GNT0;
            end else if (m1_sel) begin
               state_d = GNT1;
            end
         end
         GNT0: begin
            s_sel     = 1'b1;
            s_we      = m0_wen;
            s_byte_en = m0_wmask;
            s_addr    = m0_addr;
            s_din     = m0_wdata;
            if (s_ack) begin
               m0_ack     = 1'b1;
               m0_rdata   = s_dout;
               last_gnt_d = 1'b0;
               state_d    = IDLE;
            end else if (timeout_hit) begin
               m0_ack     = 1'b1;
               m0_err     = 1'b1;
               last_gnt_d = 1'b0;
               state_d    = IDLE;
            end
         end
         GNT1: begin
            s_sel     = 1'b1;
            s_we      = m1_wen;
            s_byte_en = m1_wmask;
            s_addr    = m1_addr;
            s_din     = m1_wdata;
            if (s_ack) begin
               m1_ack     = 1'b1;
               m1_rdata   = s_dout;
               last_gnt_d = 1'b1;
               state_d    = IDLE;
            end else if (timeout_hit) begin
               m1_ack     = 1'b1;
               m1_err     = 1'b1;
               last_gnt_d = 1'b1;
               state_d    = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: stimulus queues expected acks, a negedge monitor checks them.
module tb_mem_arbiter;

   localparam int unsigned AW = 32;
   localparam int unsigned DW = 32;

   logic            clk;
   logic            rst_n;
   logic            m0_sel, m0_wen, m1_sel, m1_wen;
   logic [AW-1:0]   m0_addr, m1_addr;
   logic [DW-1:0]   m0_wdata, m1_wdata;
   logic [DW/8-1:0] m0_wmask, m1_wmask;
   logic [DW-1:0]   m0_rdata, m1_rdata;
   logic            m0_ack, m0_err, m1_ack, m1_err;
   logic            s_sel, s_we, s_ack;
   logic [DW/8-1:0] s_byte_en;
   logic [AW-1:0]   s_addr;
   logic [DW-1:0]   s_din, s_dout;

   typedef struct packed {
      logic          mst;
      logic [DW-1:0] rdata;
      logic          err;
   } exp_t;

   exp_t sb[$];
   int   n_cmp = 0;
   int   n_err = 0;

   mem_arbiter #(.AW(AW), .DW(DW), .TIMEOUT_CYCLES(4)) dut (
      .clk(clk), .rst_n(rst_n),
      .m0_sel(m0_sel), .m0_wen(m0_wen), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
      .m0_wmask(m0_wmask), .m0_rdata(m0_rdata), .m0_ack(m0_ack), .m0_err(m0_err),
      .m1_sel(m1_sel), .m1_wen(m1_wen), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
      .m1_wmask(m1_wmask), .m1_rdata(m1_rdata), .m1_ack(m1_ack), .m1_err(m1_err),
      .s_sel(s_sel), .s_we(s_we), .s_byte_en(s_byte_en), .s_addr(s_addr),
      .s_din(s_din), .s_dout(s_dout), .s_ack(s_ack)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic mst, input logic [DW-1:0] rd, input logic err);
      exp_t e;
      e.mst   = mst;
      e.rdata = rd;
      e.err   = err;
      sb.push_back(e);
   endtask

   // Monitor: every acked cycle must match the head of the scoreboard.
   always @(negedge clk) begin
      exp_t e;
      if (rst_n) begin
         if (m0_ack || m1_ack) begin
            n_cmp++;
            if (sb.size() == 0) begin
               n_err++;
               $display("FAIL unexpected_ack: got m0_ack=%0b m1_ack=%0b expected none", m0_ack, m1_ack);
            end else begin
               e = sb.pop_front();
               if ((m0_ack && m1_ack) || (m1_ack !== e.mst) ||
                   ((e.mst ? m1_rdata : m0_rdata) !== e.rdata) ||
                   ((e.mst ? m1_err : m0_err) !== e.err) ||
                   ((e.mst ? m0_rdata : m1_rdata) !== '0) ||
                   ((e.mst ? m0_err : m1_err) !== 1'b0)) begin
                  n_err++;
                  $display("FAIL ack_check: got m0_ack=%0b m1_ack=%0b m0_rdata=0x%08h m1_rdata=0x%08h m0_err=%0b m1_err=%0b expected m%0d rdata=0x%08h err=%0b",
                           m0_ack, m1_ack, m0_rdata, m1_rdata, m0_err, m1_err, e.mst, e.rdata, e.err);
               end
            end
         end else begin
            n_cmp++;
            if (m0_rdata !== '0 || m1_rdata !== '0 || m0_err !== 1'b0 || m1_err !== 1'b0) begin
               n_err++;
               $display("FAIL no_ack_outputs: got m0_rdata=0x%08h m1_rdata=0x%08h m0_err=%0b m1_err=%0b expected all 0",
                        m0_rdata, m1_rdata, m0_err, m1_err);
            end
         end
      end
   end

   initial begin
      logic exp_order [4];
      exp_order[0] = 1'b1; exp_order[1] = 1'b0; exp_order[2] = 1'b1; exp_order[3] = 1'b0;

      // Reset with both masters requesting and non-zero inputs.
      rst_n = 1'b0;
      m0_sel = 1'b1; m0_wen = 1'b1; m0_addr = 32'h100; m0_wdata = 32'h11111111; m0_wmask = 4'hF;
      m1_sel = 1'b1; m1_wen = 1'b0; m1_addr = 32'h200; m1_wdata = 32'h22222222; m1_wmask = 4'hF;
      s_ack = 1'b0; s_dout = 32'hFFFFFFFF;
      @(negedge clk);
      chk("rst_s_sel", 64'(s_sel), 64'd0);
      chk("rst_s_we", 64'(s_we), 64'd0);
      chk("rst_s_byte_en", 64'(s_byte_en), 64'd0);
      chk("rst_s_addr", 64'(s_addr), 64'd0);
      chk("rst_s_din", 64'(s_din), 64'd0);
      chk("rst_acks", 64'({m0_ack, m1_ack, m0_err, m1_err}), 64'd0);
      chk("rst_rdata", 64'({m0_rdata, m1_rdata}), 64'd0);
      @(posedge clk);
      #1 rst_n = 1'b1;

      // First tie after reset goes to m1.
      cyc();
      s_ack = 1'b1; s_dout = 32'hAAAA5555;
      push(1'b1, 32'hAAAA5555, 1'b0);
      @(negedge clk);
      chk("first_gnt_s_sel", 64'(s_sel), 64'd1);
      chk("first_gnt_s_addr", 64'(s_addr), 64'h200);
      cyc();
      s_ack = 1'b0; m0_sel = 1'b0; m1_sel = 1'b0;
      @(negedge clk);
      chk("first_gnt_idle", 64'(s_sel), 64'd0);

      // Single read on m0, slave acks in the first select cycle.
      cyc();
      m0_sel = 1'b1; m0_wen = 1'b0; m0_addr = 32'h10;
      cyc();
      s_ack = 1'b1; s_dout = 32'hDEADBEEF;
      push(1'b0, 32'hDEADBEEF, 1'b0);
      @(negedge clk);
      chk("read_s_sel", 64'(s_sel), 64'd1);
      chk("read_s_addr", 64'(s_addr), 64'h10);
      chk("read_s_we", 64'(s_we), 64'd0);
      cyc();
      s_ack = 1'b0; m0_sel = 1'b0;
      @(negedge clk);
      chk("read_s_sel_drop", 64'(s_sel), 64'd0);
      chk("read_m0_ack_pulse", 64'(m0_ack), 64'd0);

      // s_ack while idle must be ignored.
      cyc();
      s_ack = 1'b1; s_dout = 32'h0BADF00D;
      @(negedge clk);
      chk("idle_ack_s_sel", 64'(s_sel), 64'd0);
      cyc();
      @(negedge clk);
      chk("idle_ack_s_sel2", 64'(s_sel), 64'd0);
      cyc();
      s_ack = 1'b0;

      // Contention: both held, each dropped for one cycle after its ack.
      m0_sel = 1'b1; m0_addr = 32'hA0; m1_sel = 1'b1; m1_addr = 32'hB0;
      for (int g = 0; g < 4; g++) begin
         cyc();
         m0_sel = 1'b1; m1_sel = 1'b1;
         s_ack = 1'b1; s_dout = 32'h1000 + 32'(g);
         push(exp_order[g], 32'h1000 + 32'(g), 1'b0);
         @(negedge clk);
         chk($sformatf("cont_gnt%0d_addr", g), 64'(s_addr), exp_order[g] ? 64'hB0 : 64'hA0);
         cyc();
         s_ack = 1'b0;
         if (exp_order[g]) m1_sel = 1'b0; else m0_sel = 1'b0;
         @(negedge clk);
         chk($sformatf("cont_gap%0d_s_sel", g), 64'(s_sel), 64'd0);
      end
      m0_sel = 1'b0; m1_sel = 1'b0;
      cyc();

      // Write passthrough on m1, ack on the third select cycle.
      m1_sel = 1'b1; m1_wen = 1'b1; m1_addr = 32'h20; m1_wdata = 32'h12345678; m1_wmask = 4'b0011;
      s_dout = 32'h0;
      cyc();
      for (int k = 0; k < 3; k++) begin
         if (k == 2) begin
            s_ack = 1'b1;
            push(1'b1, 32'h0, 1'b0);
         end
         @(negedge clk);
         chk($sformatf("wr%0d_s_we", k), 64'(s_we), 64'd1);
         chk($sformatf("wr%0d_s_byte_en", k), 64'(s_byte_en), 64'b0011);
         chk($sformatf("wr%0d_s_din", k), 64'(s_din), 64'h12345678);
         chk($sformatf("wr%0d_m1_ack", k), 64'(m1_ack), (k == 2) ? 64'd1 : 64'd0);
         cyc();
      end
      s_ack = 1'b0; m1_sel = 1'b0; m1_wen = 1'b0;

      // Async reset in the middle of an m0 grant.
      cyc();
      m0_sel = 1'b1; m0_addr = 32'h30;
      cyc();
      @(negedge clk);
      chk("arst_pre_s_sel", 64'(s_sel), 64'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_s_sel", 64'(s_sel), 64'd0);
      chk("arst_m0_ack", 64'(m0_ack), 64'd0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      cyc();
      s_ack = 1'b1; s_dout = 32'h55AA55AA;
      push(1'b0, 32'h55AA55AA, 1'b0);
      @(negedge clk);
      chk("arst_regrant_addr", 64'(s_addr), 64'h30);
      cyc();
      s_ack = 1'b0; m0_sel = 1'b0;
      cyc();

      // Slave never acks.
      m0_sel = 1'b1; m0_addr = 32'h40; s_dout = 32'hFFFFFFFF;
      cyc();
`ifdef ARB_TIMEOUT_EN
      for (int k = 1; k < 4; k++) begin
         @(negedge clk);
         chk($sformatf("to_wait%0d_s_sel", k), 64'(s_sel), 64'd1);
         cyc();
      end
      push(1'b0, 32'h0, 1'b1);
      @(negedge clk);
      chk("to_m0_err", 64'(m0_err), 64'd1);
      cyc();
      m0_sel = 1'b0;
      @(negedge clk);
      chk("to_s_sel_drop", 64'(s_sel), 64'd0);
`else
      for (int k = 1; k < 10; k++) begin
         @(negedge clk);
         chk($sformatf("nto_wait%0d_s_sel", k), 64'(s_sel), 64'd1);
         cyc();
      end
      s_ack = 1'b1; s_dout = 32'hC0FFEE00;
      push(1'b0, 32'hC0FFEE00, 1'b0);
      @(negedge clk);
      chk("nto_s_sel", 64'(s_sel), 64'd1);
      cyc();
      s_ack = 1'b0; m0_sel = 1'b0;
      @(negedge clk);
      chk("nto_s_sel_drop", 64'(s_sel), 64'd0);
`endif

      cyc();
      cyc();
      chk("scoreboard_drained", 64'(sb.size()), 64'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Two-master, one-slave arbiter that shares the single data SRAM (sel/we/byte_en/addr/din/dout/ack handshake) between the load/store unit (master 1) and a second requester such as a fetch or debug/DMA port (master 0).
- Sits between the requesters and the sram instance in core.
- Uses round-robin arbitration with a registered grant, and holds the grant for the whole transaction until the slave ack.

Parameters:
- AW, 32, address width.
- DW, 32, data width; byte mask is DW/8 bits.
- TIMEOUT_CYCLES, 255, maximum cycles a grant waits for s_ack. Used only with ARB_TIMEOUT_EN.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- m0_sel  in  1  master 0 request; held until m0_ack
- m0_wen  in  1  master 0 write enable
- m0_addr  in  AW  master 0 address
- m0_wdata  in  DW  master 0 write data
- m0_wmask  in  DW/8  master 0 byte mask
- m0_rdata  out  DW  master 0 read data; valid when m0_ack=1
- m0_ack  out  1  master 0 transaction complete, one-cycle pulse
- m0_err  out  1  master 0 transaction aborted; qualified by m0_ack
- m1_sel, m1_wen, m1_addr, m1_wdata, m1_wmask, m1_rdata, m1_ack, m1_err  same as m0_* for master 1
- s_sel  out  1  slave select
- s_we  out  1  slave write enable
- s_byte_en  out  DW/8  slave byte mask
- s_addr  out  AW  slave address
- s_din  out  DW  slave write data
- s_dout  in  DW  slave read data
- s_ack  in  1  slave ack

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on rst_n.
- Reset values:
  - State IDLE; last_gnt=0, so master 1 wins the first tie; timeout counter 0.
  - Because state is IDLE, all outputs are 0: s_sel, s_we, s_byte_en, s_addr, s_din, m*_ack, m*_err, m*_rdata.
  - Reset mid-transaction returns to IDLE at once; s_sel drops asynchronously and no ack is issued.
- FSM states: IDLE, GNT0, GNT1.
- IDLE:
  - s_sel=0.
  - If exactly one m*_sel is high, go to GNT of that master next cycle.
  - If both are high, grant the master not equal to last_gnt.
  - Otherwise stay in IDLE.
- GNTx (x = 0 or 1):
  - Slave outputs are combinationally muxed from master x: s_sel=1, s_we=mx_wen, s_addr, s_din=mx_wdata, s_byte_en=mx_wmask.
  - On s_ack=1: mx_ack=1 and mx_rdata=s_dout in the same cycle; last_gnt<=x; next state IDLE.
  - The other master's ack, err and rdata stay 0.
- Latency: a request seen in cycle N drives s_sel in cycle N+1. Minimum request-to-ack is 2 cycles when the slave acks in the same cycle as select.
- Masters must deassert sel in the cycle after ack. A sel still high in IDLE is treated as a new request.
- Back-to-back: one IDLE cycle between grants. With both masters requesting continuously, grants alternate 1,0,1,0.
- A master's sel dropping while granted is a protocol violation; the grant is held until s_ack regardless.
- m*_rdata is 0 whenever its ack is 0.
- s_ack in IDLE is ignored.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- With the macro:
  - A counter clears on entry to GNTx and increments each cycle without s_ack.
  - When the counter reaches TIMEOUT_CYCLES-1 with no s_ack, the block pulses mx_ack=1 and mx_err=1 with mx_rdata=0, drops s_sel, updates last_gnt and returns to IDLE.
  - s_ack in that same cycle wins: normal completion, err=0.
- Without the macro: no counter; the grant waits indefinitely; m0_err and m1_err are tied 0.

Test Plan:
- Reset: hold rst_n=0 with both sels high -> all outputs 0. Release -> first grant goes to m1 (s_addr=m1_addr in cycle 1).
- Single read: m0_sel=1, m0_wen=0, addr=0x10, slave acks in the first select cycle with s_dout=0xDEADBEEF -> s_sel high for 1 cycle, m0_ack pulse 1 cycle, m0_rdata=0xDEADBEEF, m1_ack=0.
- Write passthrough: m1 write, addr=0x20, wdata=0x12345678, wmask=4'b0011, slave ack after 3 cycles -> s_we=1, s_byte_en=0011, s_din stable 3 cycles, m1_ack on the ack cycle.
- Contention: both sel held, each dropped 1 cycle after its ack and reasserted -> grant order 1,0,1,0 with one IDLE cycle between grants.
- Async reset mid-grant: rst_n low while in GNT0 before ack -> s_sel=0 immediately, no m0_ack. After release, m0 is re-arbitrated normally.
- Timeout (with ARB_TIMEOUT_EN, TIMEOUT_CYCLES=4): slave never acks -> m0_ack=1 and m0_err=1 on the 4th grant cycle, m0_rdata=0, s_sel drops. Without the macro, s_sel stays high.
